hc04_scheduler: RTL and testbench

Round-robin measurement controller for up to NUM_SENSORS HC-SR04 ultrasonic rangers sharing one timing engine. It issues one trigger pulse at a time, times the returned echo in microseconds, and publishes each result as a single-cycle strobe. Sensors fire one after another with an enforced quiet gap so that one sensor cannot pick up another sensor's ping. The block sits between the sensor pins (hc04_trigger/hc04_echo) and the robot's distance register file.

---
 rtl/hc04_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_hc04_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hc04_scheduler.sv
// Round-robin HC-SR04 measurement controller: one trigger at a time, echo timed in us.
// Optional HC04_DEGLITCH_EN adds a 3-sample majority filter after each echo synchronizer.
module hc04_scheduler #(
  parameter int NUM_SENSORS = 4,
  parameter int US_DIV      = 50,
  parameter int TRIG_US     = 12,
  parameter int TIMEOUT_US  = 30000,
  parameter int GAP_US      = 10000,
  parameter int IDX_W       = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  output logic [NUM_SENSORS-1:0] hc04_trigger,
  input  logic [NUM_SENSORS-1:0] hc04_echo,
  output logic                   busy,
  output logic                   dist_valid,
  output logic [IDX_W-1:0]       dist_idx,
  output logic [15:0]            dist_us,
  output logic                   dist_timeout
);

  localparam int PRE_W = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TRIG = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_MEAS = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  logic [NUM_SENSORS-1:0] sync1_q, sync2_q, echo_f, prev_q;
  logic [2:0]             state_q, state_d;
  logic [IDX_W-1:0]       sel_q, sel_d, next_sel, lo_sel, hi_sel;
  logic                   started_q, started_d, hi_found;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [15:0]            us_q, us_d, meas_val, post_val;
  logic [NUM_SENSORS-1:0] trig_q, trig_d;
  logic                   tick, enter, post, post_to, echo_sel, prev_sel;
  logic                   valid_q, to_q;
  logic [IDX_W-1:0]       idx_q;
  logic [15:0]            dout_q;
  int                     base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= hc04_echo;
      sync2_q <= sync1_q;
      prev_q  <= echo_f;
    end
  end

`ifdef HC04_DEGLITCH_EN
  logic [NUM_SENSORS-1:0] hist0_q, hist1_q, filt_q;

  // Majority of three consecutive samples: single-cycle pulses never win a vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0_q <= '0;
      hist1_q <= '0;
      filt_q  <= '0;
    end else begin
      hist0_q <= sync2_q;
      hist1_q <= hist0_q;
      filt_q  <= (sync2_q & hist0_q) | (sync2_q & hist1_q) | (hist0_q & hist1_q);
    end
  end
  assign echo_f = filt_q;
`else
  assign echo_f = sync2_q;
`endif

  assign echo_sel = echo_f[sel_q];
  assign prev_sel = prev_q[sel_q];
  assign tick     = (pre_q == PRE_W'(US_DIV - 1));
  // The current cycle's tick is folded in so the width is truncated, never short by one.
  assign meas_val = (tick && us_q != 16'hFFFF) ? us_q + 16'd1 : us_q;

  // Next channel: smallest set mask bit at or above base, otherwise wrap to the smallest.
  always_comb begin
    base     = started_q ? int'(sel_q) + 1 : 0;
    lo_sel   = '0;
    hi_sel   = '0;
    hi_found = 1'b0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (sensor_mask[i]) begin
        lo_sel = IDX_W'(i);
        if (i >= base) begin
          hi_sel   = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    next_sel = hi_found ? hi_sel : lo_sel;
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    started_d = started_q;
    post      = 1'b0;
    post_to   = 1'b0;
    post_val  = us_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && sensor_mask != '0) begin
          sel_d     = next_sel;
          started_d = 1'b1;
          state_d   = ST_TRIG;
        end
      end
      ST_TRIG: begin
        if (tick && us_q == 16'(TRIG_US - 1)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (echo_sel && !prev_sel) begin
          state_d = ST_MEAS;
        end else if (tick && us_q == 16'(TIMEOUT_US - 1)) begin
          post    = 1'b1;
          post_to = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_MEAS: begin
        if (!echo_sel && prev_sel) begin
          post     = 1'b1;
          post_val = meas_val;
          state_d  = ST_GAP;
        end else if (tick && us_q == 16'(TIMEOUT_US - 1)) begin
          post    = 1'b1;
          post_to = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick && us_q == 16'(GAP_US - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    enter = (state_d != state_q);
    pre_d = (enter || tick) ? '0 : pre_q + PRE_W'(1);
    if (enter)                        us_d = '0;
    else if (tick && us_q != 16'hFFFF) us_d = us_q + 16'd1;
    else                              us_d = us_q;

    trig_d = '0;
    if (state_d == ST_TRIG) trig_d[sel_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      started_q <= 1'b0;
      pre_q     <= '0;
      us_q      <= '0;
      trig_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      dout_q    <= '0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      started_q <= started_d;
      pre_q     <= pre_d;
      us_q      <= us_d;
      trig_q    <= trig_d;
      valid_q   <= post;
      if (post) begin
        idx_q  <= sel_q;
        dout_q <= post_to ? 16'hFFFF : post_val;
        to_q   <= post_to;
      end
    end
  end

  assign hc04_trigger = trig_q;
  assign busy         = (state_q != ST_IDLE);
  assign dist_valid   = valid_q;
  assign dist_idx     = idx_q;
  assign dist_us      = dout_q;
  assign dist_timeout = to_q;

endmodule

// File: tb/tb_hc04_scheduler.sv
// Directed self-checking bench for hc04_scheduler (US_DIV=50, TRIG_US=12, TIMEOUT_US=100, GAP_US=20).
module tb_hc04_scheduler;

  localparam int N       = 4;
  localparam int TRIG_CY = 12 * 50;
  localparam int GAP_CY  = 20 * 50;
  localparam int TO_CY   = 100 * 50;
`ifdef HC04_DEGLITCH_EN
  localparam int FALL_LAT = 5;
`else
  localparam int FALL_LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [N-1:0] sensor_mask;
  logic [N-1:0] hc04_trigger;
  logic [N-1:0] hc04_echo;
  logic         busy;
  logic         dist_valid;
  logic [1:0]   dist_idx;
  logic [15:0]  dist_us;
  logic         dist_timeout;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCnt    = 0;
  int lastFall    = 0;
  bit hasFall     = 0;
  int overlapErr  = 0;
  int doubleValid = 0;
  logic prevValid = 1'b0;

  hc04_scheduler #(
    .NUM_SENSORS(N), .US_DIV(50), .TRIG_US(12), .TIMEOUT_US(100), .GAP_US(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_mask(sensor_mask),
    .hc04_trigger(hc04_trigger), .hc04_echo(hc04_echo), .busy(busy),
    .dist_valid(dist_valid), .dist_idx(dist_idx), .dist_us(dist_us),
    .dist_timeout(dist_timeout)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Background monitor for properties that must hold at every cycle.
  always @(negedge clk) begin
    if ($countones(hc04_trigger) > 1) overlapErr++;
    if (dist_valid && prevValid) doubleValid++;
    prevValid = dist_valid;
  end

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic waitTrigRise(input string tag, input int expCh);
    int n;
    n = 0;
    while (hc04_trigger == '0 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_rise_seen"}, 32'(hc04_trigger != '0), 1);
    checkOutput({tag, "_onehot"}, 32'(hc04_trigger), 32'(1 << expCh));
  endtask

  task automatic expectTrigger(input string tag, input int expCh);
    int width;
    int riseAt;
    waitTrigRise(tag, expCh);
    riseAt = cycleCnt;
    if (hasFall) checkOutput({tag, "_gap_ok"}, 32'((riseAt - lastFall) >= GAP_CY), 1);
    width = 0;
    while (hc04_trigger != '0 && width < 4 * TRIG_CY) begin
      width++;
      @(negedge clk);
    end
    checkOutput({tag, "_width"}, 32'(width), 32'(TRIG_CY));
    lastFall = cycleCnt;
    hasFall  = 1;
  endtask

  task automatic applyStimulus(input int ch, input int delayCyc, input int widthCyc);
    repeat (delayCyc) @(negedge clk);
    hc04_echo[ch] = 1'b1;
    repeat (widthCyc) @(negedge clk);
    hc04_echo[ch] = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dist_valid && lat < budget);
    checkOutput({tag, "_valid_seen"}, 32'(dist_valid), 1);
  endtask

  task automatic checkResult(input string tag, input int idx, input int us, input int to);
    checkOutput({tag, "_idx"}, 32'(dist_idx), 32'(idx));
    checkOutput({tag, "_us"}, 32'(dist_us), 32'(us));
    checkOutput({tag, "_timeout"}, 32'(dist_timeout), 32'(to));
  endtask

  initial begin
    int lat;
    int trigSeen;
    int order[3]  = '{1, 3, 0};
    int widths[3] = '{1000, 1675, 350};
    int expUs[3]  = '{20, 33, 7};

    rst_n = 1'b0;
    enable = 1'b0;
    sensor_mask = '0;
    hc04_echo = '0;
    repeat (5) @(negedge clk);
    checkOutput("rst_trigger", 32'(hc04_trigger), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_valid", 32'(dist_valid), 0);
    checkResult("rst", 0, 0, 0);

    $display("[TB] single sensor measurement");
    rst_n = 1'b1;
    sensor_mask = 4'b0001;
    enable = 1'b1;
    expectTrigger("s0", 0);
    applyStimulus(0, 50, 2900);
    waitValid("s0", 100, lat);
    checkOutput("s0_fall_latency", 32'(lat), 32'(FALL_LAT));
    checkResult("s0", 0, 58, 0);

    $display("[TB] rotation over mask 1011");
    sensor_mask = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      expectTrigger($sformatf("rot%0d", k), order[k]);
      if (order[k] == 1) begin
        repeat (20) @(negedge clk);
        hc04_echo[2] = 1'b1;
        repeat (100) @(negedge clk);
        hc04_echo[2] = 1'b0;
      end
      applyStimulus(order[k], 50, widths[k]);
      waitValid($sformatf("rot%0d", k), 100, lat);
      checkResult($sformatf("rot%0d", k), order[k], expUs[k], 0);
    end

    $display("[TB] no echo on channel 2");
    sensor_mask = 4'b0100;
    expectTrigger("noecho", 2);
    waitValid("noecho", TO_CY + 100, lat);
    checkOutput("noecho_latency", 32'(lat), 32'(TO_CY));
    checkResult("noecho", 2, 16'hFFFF, 1);
    sensor_mask = 4'b1111;
    expectTrigger("after_to", 3);

    $display("[TB] echo stuck high");
    repeat (50) @(negedge clk);
    hc04_echo[3] = 1'b1;
    waitValid("stuck", TO_CY + 200, lat);
    checkResult("stuck", 3, 16'hFFFF, 1);
    sensor_mask = 4'b1000;
    expectTrigger("stale", 3);
    repeat (500) @(negedge clk);
    hc04_echo[3] = 1'b0;
    repeat (500) @(negedge clk);
    applyStimulus(3, 0, 750);
    waitValid("stale", 100, lat);
    checkResult("stale", 3, 15, 0);

    $display("[TB] reset during trigger");
    sensor_mask = 4'b0010;
    waitTrigRise("rstmid", 1);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_trigger", 32'(hc04_trigger), 0);
    checkOutput("rstmid_busy", 32'(busy), 0);
    checkResult("rstmid", 0, 0, 0);
    repeat (3) @(negedge clk);
    sensor_mask = 4'b1111;
    hasFall = 0;
    rst_n = 1'b1;
    expectTrigger("restart", 0);

    $display("[TB] single-cycle echo glitch");
    repeat (50) @(negedge clk);
    hc04_echo[0] = 1'b1;
    @(negedge clk);
    hc04_echo[0] = 1'b0;
    waitValid("glitch", TO_CY + 200, lat);
`ifdef HC04_DEGLITCH_EN
    checkResult("glitch", 0, 16'hFFFF, 1);
`else
    checkResult("glitch", 0, 0, 0);
`endif

    $display("[TB] enable dropped");
    enable = 1'b0;
    lat = 0;
    while (busy && lat < GAP_CY + 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("disable_idle", 32'(busy), 0);
    trigSeen = 0;
    repeat (2000) begin
      @(negedge clk);
      if (hc04_trigger != '0 || busy) trigSeen++;
    end
    checkOutput("disable_quiet", 32'(trigSeen), 0);
    checkOutput("no_trigger_overlap", 32'(overlapErr), 0);
    checkOutput("valid_single_cycle", 32'(doubleValid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
